// File: rtl/adder_pkg.sv
// adder_pkg: shared word width and FSM state encoding for the word-serial adder
package adder_pkg;
    localparam int WORD_W = 16;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/sixteen_adder.sv
// sixteen_adder: 16-bit ripple-free adder slice with carry-in and carry-out
//   in1, in2 : 16-bit addends
//   Cin      : carry-in
//   Cout     : carry-out
//   out      : 16-bit sum
module sixteen_adder (
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    input  logic        Cin,
    output logic        Cout,
    output logic [15:0] out
);
    assign {Cout, out} = 17'(in1) + 17'(in2) + 17'(Cin);
endmodule

// File: rtl/multiword_adder_seq.sv
// multiword_adder_seq: word-serial W-bit adder, one 16-bit slice per clock, LSW first
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake (ready only in IDLE)
//   a, b, cin           : W-bit operands and carry-in
//   out_valid/out_ready : result handshake (valid only in DONE)
//   sum, cout           : registered W-bit sum and carry-out of the top slice
module multiword_adder_seq
    import adder_pkg::*;
#(
    parameter  int WORDS = 4,
    localparam int W     = WORD_W * WORDS,
    localparam int IW    = $clog2(WORDS + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout
);
    state_t              state_q;
    logic [IW-1:0]       idx_q;
    logic                carry_q;
    logic                cout_q;
    logic [W-1:0]        op_a_q;
    logic [W-1:0]        op_b_q;
    logic [W-1:0]        sum_q;
    logic [WORD_W-1:0]   slice_a;
    logic [WORD_W-1:0]   slice_b;
    logic [WORD_W-1:0]   slice_sum;
    logic                slice_cout;

    assign slice_a = op_a_q[idx_q*WORD_W +: WORD_W];
    assign slice_b = op_b_q[idx_q*WORD_W +: WORD_W];

    sixteen_adder u_add (
        .in1  (slice_a),
        .in2  (slice_b),
        .Cin  (carry_q),
        .Cout (slice_cout),
        .out  (slice_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    op_a_q  <= a;
                    op_b_q  <= b;
                    carry_q <= cin;
                    idx_q   <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    sum_q[idx_q*WORD_W +: WORD_W] <= slice_sum;
                    carry_q <= slice_cout;
                    idx_q   <= idx_q + IW'(1);
                    if (idx_q == IW'(WORDS - 1)) begin
                        cout_q  <= slice_cout;
                        state_q <= DONE;
                    end
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
endmodule

// File: tb/tb_multiword_adder_seq.sv
// tb_multiword_adder_seq: directed self-checking bench for multiword_adder_seq (WORDS=4 and WORDS=1)
module tb_multiword_adder_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] sum;
    logic        cout;

    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [15:0] s_a = '0;
    logic [15:0] s_b = '0;
    logic        s_cin = 1'b0;
    logic        s_out_valid;
    logic        s_out_ready = 1'b0;
    logic [15:0] s_sum;
    logic        s_cout;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multiword_adder_seq #(.WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    multiword_adder_seq #(.WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .cin(s_cin), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .sum(s_sum), .cout(s_cout)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] s;
        logic        c;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Sample after each edge until out_valid rises; lat counts edges since accept.
    task automatic wait_done(input string nm, output int lat);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (out_valid === 1'b1) return;
        end
        chk({nm, " timeout"}, 64'(out_valid), 64'd1);
    endtask

    task automatic run(input logic [63:0] av, input logic [63:0] bv, input logic cv,
                       input logic [63:0] es, input logic ec, input string nm);
        int lat;
        @(negedge clk);
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        chk({nm, " in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        wait_done(nm, lat);
        chk({nm, " latency"}, 64'(lat), 64'd4);
        chk({nm, " sum"}, sum, es);
        chk({nm, " cout"}, 64'(cout), 64'(ec));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({nm, " out_valid drop"}, 64'(out_valid), 64'd0);
        chk({nm, " back idle"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        vec_t vecs[6];
        int   lat;
        int   seen;
        logic [63:0] held;
        vecs[0] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[1] = '{64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0, 1'b1};
        vecs[2] = '{64'h0000_FFFF_0000_FFFF, 64'h1, 1'b0, 64'h0000_FFFF_0001_0000, 1'b0};
        vecs[3] = '{64'h8844_8844_8844_8844, 64'h6280_6280_6280_6280, 1'b1, 64'hEAC4_EAC4_EAC4_EAC5, 1'b0};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[5] = '{64'h1234_5678_9ABC_DEF0, 64'h0, 1'b1, 64'h1234_5678_9ABC_DEF1, 1'b0};

        repeat (2) @(negedge clk);
        chk("reset sum", sum, 64'h0);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("idle reset sum", sum, 64'h0);
        chk("idle reset cout", 64'(cout), 64'd0);
        chk("idle reset in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after reset in_ready", 64'(in_ready), 64'd1);
        chk("after reset out_valid", 64'(out_valid), 64'd0);

        for (int i = 0; i < 6; i++)
            run(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c, $sformatf("vec%0d", i));

        // X on operands while idle and not valid must leave the FSM idle
        @(negedge clk);
        a = 'x; b = 'x; cin = 1'bx;
        repeat (3) @(negedge clk);
        chk("x idle in_ready", 64'(in_ready), 64'd1);
        chk("x idle out_valid", 64'(out_valid), 64'd0);

        // Backpressure: result held, new operands stalled
        @(negedge clk);
        a = vecs[3].a; b = vecs[3].b; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 a = vecs[2].a; b = vecs[2].b; cin = 1'b0;
        wait_done("bp first", lat);
        chk("bp first sum", sum, vecs[3].s);
        held = sum;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp out_valid held", 64'(out_valid), 64'd1);
            chk("bp in_ready low", 64'(in_ready), 64'd0);
            chk("bp sum held", sum, held);
            chk("bp cout held", 64'(cout), 64'(vecs[3].c));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp release idle", 64'(in_ready), 64'd1);
        chk("bp release out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_done("bp second", lat);
        chk("bp second latency", 64'(lat), 64'd4);
        chk("bp second sum", sum, vecs[2].s);
        chk("bp second cout", 64'(cout), 64'(vecs[2].c));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        // Reset after two RUN cycles aborts the transaction
        @(negedge clk);
        a = vecs[4].a; b = vecs[4].b; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("abort sum", sum, 64'h0);
        chk("abort cout", 64'(cout), 64'd0);
        chk("abort in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        chk("abort never valid", 64'(seen), 64'd0);
        chk("abort sum stays", sum, 64'h0);
        run(vecs[3].a, vecs[3].b, vecs[3].cin, vecs[3].s, vecs[3].c, "post abort");

        // WORDS=1 instance: single RUN cycle
        @(negedge clk);
        s_a = 16'hFFFF; s_b = 16'h0001; s_cin = 1'b0; s_in_valid = 1'b1;
        @(posedge clk);
        #1 s_in_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (s_out_valid === 1'b1) break;
        end
        chk("w1 latency", 64'(lat), 64'd1);
        chk("w1 sum", 64'(s_sum), 64'h0);
        chk("w1 cout", 64'(s_cout), 64'd1);
        s_out_ready = 1'b1;
        @(posedge clk);
        #1 s_out_ready = 1'b0;
        @(negedge clk);
        chk("w1 back idle", 64'(s_in_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
